// File: rtl/matmul_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// matmul_pkg : shared types and default sizes for the matrix-multiply datapath
// Revision   : 1.0
// ----------------------------------------------------------------------------
package matmul_pkg;

  localparam int MM_DATA_WIDTH    = 32;
  localparam int MM_MAT_DIM_WIDTH = 3;
  localparam int MM_RD_LATENCY    = 2;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_DRAIN = 2'd2,
    S_RSP   = 2'd3
  } state_t;

endpackage
`default_nettype wire

// File: rtl/matmul_operand_fetch_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// matmul_operand_fetch_if : request/response bundle between engine and fetch
// Revision                : 1.0
// ----------------------------------------------------------------------------
interface matmul_operand_fetch_if
  import matmul_pkg::*;
#(
  parameter int DATA_WIDTH    = MM_DATA_WIDTH,
  parameter int MAT_DIM_WIDTH = MM_MAT_DIM_WIDTH
);
  localparam int MAT_DIM_SIZE = 2 ** MAT_DIM_WIDTH;

  logic                                     req_vld;
  logic                                     req_rdy;
  logic [MAT_DIM_WIDTH-1:0]                 i;
  logic [MAT_DIM_WIDTH-1:0]                 j;
  logic [MAT_DIM_SIZE-1:0][DATA_WIDTH-1:0]  x_r_row;
  logic [MAT_DIM_SIZE-1:0][DATA_WIDTH-1:0]  y_r_col;
  logic                                     rsp_vld;
  logic                                     rsp_rdy;

  modport master (
    output req_vld, i, j, rsp_rdy,
    input  req_rdy, x_r_row, y_r_col, rsp_vld
  );

  modport slave (
    input  req_vld, i, j, rsp_rdy,
    output req_rdy, x_r_row, y_r_col, rsp_vld
  );

endinterface
`default_nettype wire

// File: rtl/mm_rd_pipe.sv
`default_nettype none
// ----------------------------------------------------------------------------
// mm_rd_pipe : valid+index delay line aligned with the BRAM read latency
// Revision   : 1.0
// ----------------------------------------------------------------------------
module mm_rd_pipe #(
  parameter int LATENCY   = 2,
  parameter int IDX_WIDTH = 3
) (
  input  wire logic                 clk,
  input  wire logic                 rst,
  input  wire logic                 in_vld,
  input  wire logic [IDX_WIDTH-1:0] in_idx,
  output logic                      out_vld,
  output logic [IDX_WIDTH-1:0]      out_idx
);

  logic [LATENCY-1:0]                vld_q, vld_d;
  logic [LATENCY-1:0][IDX_WIDTH-1:0] idx_q, idx_d;

  always_comb begin
    vld_d    = vld_q;
    idx_d    = idx_q;
    vld_d[0] = in_vld;
    idx_d[0] = in_idx;
    for (int s = 1; s < LATENCY; s++) begin
      vld_d[s] = vld_q[s-1];
      idx_d[s] = idx_q[s-1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q <= '0;
      idx_q <= '0;
    end else begin
      vld_q <= vld_d;
      idx_q <= idx_d;
    end
  end

  assign out_vld = vld_q[LATENCY-1];
  assign out_idx = idx_q[LATENCY-1];

endmodule
`default_nettype wire

// File: rtl/matmul_operand_fetch.sv
`default_nettype none
// ----------------------------------------------------------------------------
// matmul_operand_fetch : serial BRAM fetch of X row i and Y column j
// Revision             : 1.0
// ----------------------------------------------------------------------------
module matmul_operand_fetch
  import matmul_pkg::*;
#(
  parameter int DATA_WIDTH    = MM_DATA_WIDTH,
  parameter int MAT_DIM_WIDTH = MM_MAT_DIM_WIDTH,
  parameter int MAT_DIM_SIZE  = 2 ** MAT_DIM_WIDTH,
  parameter int ADDR_WIDTH    = 2 * MAT_DIM_WIDTH
) (
  input  wire logic                  clk,
  input  wire logic                  rst,
  matmul_operand_fetch_if.slave      bus,
  output logic                       x_re,
  output logic                       y_re,
  output logic [ADDR_WIDTH-1:0]      x_addr,
  output logic [ADDR_WIDTH-1:0]      y_addr,
  input  wire logic [DATA_WIDTH-1:0] x_rd_data,
  input  wire logic [DATA_WIDTH-1:0] y_rd_data
);

  localparam logic [MAT_DIM_WIDTH-1:0] K_LAST = MAT_DIM_WIDTH'(MAT_DIM_SIZE - 1);
  localparam logic [MAT_DIM_WIDTH-1:0] K_ZERO = '0;

  typedef logic [MAT_DIM_SIZE-1:0][DATA_WIDTH-1:0] vec_t;

  state_t                   state_q, state_d;
  logic [MAT_DIM_WIDTH-1:0] k_q, k_d;
  logic [MAT_DIM_WIDTH-1:0] i_q, i_d;
  logic [MAT_DIM_WIDTH-1:0] j_q, j_d;
  logic                     x_re_q, x_re_d;
  logic                     y_re_q, y_re_d;
  logic [ADDR_WIDTH-1:0]    x_addr_q, x_addr_d;
  logic [ADDR_WIDTH-1:0]    y_addr_q, y_addr_d;
  logic                     rsp_vld_q, rsp_vld_d;
  vec_t                     x_row_q, x_row_d;
  vec_t                     y_col_q, y_col_d;

  logic                     cap_vld;
  logic [MAT_DIM_WIDTH-1:0] cap_idx;

  // The pipe is fed with the read being issued this edge, so its second
  // stage lines up with the cycle in which the BRAM data is on the bus.
  mm_rd_pipe #(
    .LATENCY   (MM_RD_LATENCY),
    .IDX_WIDTH (MAT_DIM_WIDTH)
  ) u_rd_pipe (
    .clk     (clk),
    .rst     (rst),
    .in_vld  (x_re_d),
    .in_idx  (k_d),
    .out_vld (cap_vld),
    .out_idx (cap_idx)
  );

  always_comb begin
    state_d   = state_q;
    k_d       = k_q;
    i_d       = i_q;
    j_d       = j_q;
    x_re_d    = 1'b0;
    y_re_d    = 1'b0;
    x_addr_d  = x_addr_q;
    y_addr_d  = y_addr_q;
    rsp_vld_d = rsp_vld_q;
    x_row_d   = x_row_q;
    y_col_d   = y_col_q;

    if (cap_vld) begin
      x_row_d[cap_idx] = x_rd_data;
      y_col_d[cap_idx] = y_rd_data;
    end

    case (state_q)
      S_IDLE: begin
        if (bus.req_vld) begin
          i_d      = bus.i;
          j_d      = bus.j;
          k_d      = K_ZERO;
          x_addr_d = {bus.i, K_ZERO};
          y_addr_d = {K_ZERO, bus.j};
          x_re_d   = 1'b1;
          y_re_d   = 1'b1;
          state_d  = S_FETCH;
        end
      end
      S_FETCH: begin
        if (k_q == K_LAST) begin
          state_d = S_DRAIN;
        end else begin
          k_d      = k_q + 1'b1;
          x_addr_d = {i_q, k_d};
          y_addr_d = {k_d, j_q};
          x_re_d   = 1'b1;
          y_re_d   = 1'b1;
        end
      end
      S_DRAIN: begin
        if (cap_vld && (cap_idx == K_LAST)) begin
          rsp_vld_d = 1'b1;
          state_d   = S_RSP;
        end
      end
      S_RSP: begin
        if (bus.rsp_rdy) begin
          rsp_vld_d = 1'b0;
          state_d   = S_IDLE;
        end
      end
      default: begin
        state_d   = S_IDLE;
        k_d       = 'x;
        x_re_d    = 1'bx;
        y_re_d    = 1'bx;
        x_addr_d  = 'x;
        y_addr_d  = 'x;
        rsp_vld_d = 1'bx;
        x_row_d   = 'x;
        y_col_d   = 'x;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      k_q       <= '0;
      i_q       <= '0;
      j_q       <= '0;
      x_re_q    <= 1'b0;
      y_re_q    <= 1'b0;
      x_addr_q  <= '0;
      y_addr_q  <= '0;
      rsp_vld_q <= 1'b0;
      x_row_q   <= '0;
      y_col_q   <= '0;
    end else begin
      state_q   <= state_d;
      k_q       <= k_d;
      i_q       <= i_d;
      j_q       <= j_d;
      x_re_q    <= x_re_d;
      y_re_q    <= y_re_d;
      x_addr_q  <= x_addr_d;
      y_addr_q  <= y_addr_d;
      rsp_vld_q <= rsp_vld_d;
      x_row_q   <= x_row_d;
      y_col_q   <= y_col_d;
    end
  end

  assign bus.req_rdy = (state_q == S_IDLE);
  assign bus.rsp_vld = rsp_vld_q;
  assign bus.x_r_row = x_row_q;
  assign bus.y_r_col = y_col_q;
  assign x_re        = x_re_q;
  assign y_re        = y_re_q;
  assign x_addr      = x_addr_q;
  assign y_addr      = y_addr_q;

endmodule
`default_nettype wire

// File: tb/tb_matmul_operand_fetch.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_matmul_operand_fetch : scoreboard bench for the operand-fetch responder
// Revision                : 1.0
// ----------------------------------------------------------------------------
module tb_matmul_operand_fetch;

  localparam int DW = 32;
  localparam int MW = 3;
  localparam int N  = 8;
  localparam int AW = 6;

  typedef logic [N-1:0][DW-1:0] vec_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          x_re, y_re;
  logic [AW-1:0] x_addr, y_addr;
  logic [DW-1:0] x_rd_data = '0;
  logic [DW-1:0] y_rd_data = '0;
  int            cyc = 0;
  int            n_cmp = 0;
  int            n_err = 0;
  vec_t          exp_x_q[$];
  vec_t          exp_y_q[$];

  matmul_operand_fetch_if #(.DATA_WIDTH(DW), .MAT_DIM_WIDTH(MW)) bus ();

  matmul_operand_fetch dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .x_re      (x_re),
    .y_re      (y_re),
    .x_addr    (x_addr),
    .y_addr    (y_addr),
    .x_rd_data (x_rd_data),
    .y_rd_data (y_rd_data)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // BRAM models: X[r][c] = r*8+c, Y[r][c] = 1000+r*8+c, row-major.
  always @(posedge clk) begin
    if (x_re) x_rd_data <= 32'(x_addr);
    if (y_re) y_rd_data <= 32'(1000 + int'(y_addr));
  end

  function automatic vec_t model_x(input logic [MW-1:0] r);
    vec_t v;
    for (int k = 0; k < N; k++) v[k] = 32'(int'(r) * 8 + k);
    return v;
  endfunction

  function automatic vec_t model_y(input logic [MW-1:0] c);
    vec_t v;
    for (int k = 0; k < N; k++) v[k] = 32'(1000 + k * 8 + int'(c));
    return v;
  endfunction

  // Drive a request and wait for acceptance; pushes the expected pair.
  task automatic do_req(input logic [MW-1:0] ri, input logic [MW-1:0] rj,
                        input bit hold, output int acc_cyc, output bit ok);
    ok = 1'b0;
    acc_cyc = 0;
    @(negedge clk);
    bus.req_vld = 1'b1;
    bus.i = ri;
    bus.j = rj;
    for (int t = 0; t < 50; t++) begin
      if (bus.req_rdy) begin
        exp_x_q.push_back(model_x(ri));
        exp_y_q.push_back(model_y(rj));
        @(posedge clk);
        #1;
        acc_cyc = cyc;
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!hold) begin
      @(negedge clk);
      bus.req_vld = 1'b0;
    end
  endtask

  task automatic wait_rsp(output int rsp_cyc, output bit ok);
    ok = 1'b0;
    rsp_cyc = 0;
    for (int t = 0; t < 50; t++) begin
      @(negedge clk);
      if (bus.rsp_vld) begin
        rsp_cyc = cyc;
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++; if (bus.req_rdy !== 1'b1) begin n_err++; $display("FAIL reset_req_rdy got %b want 1", bus.req_rdy); end
    n_cmp++; if ({x_re, y_re, bus.rsp_vld} !== 3'b000) begin n_err++; $display("FAIL reset_en got %b want 000", {x_re, y_re, bus.rsp_vld}); end
    n_cmp++; if ({x_addr, y_addr} !== '0) begin n_err++; $display("FAIL reset_addr got %h want 0", {x_addr, y_addr}); end
    n_cmp++; if ({bus.x_r_row, bus.y_r_col} !== '0) begin n_err++; $display("FAIL reset_vec got nonzero want 0"); end
    rst = 1'b0;
    @(negedge clk);
    n_cmp++; if (bus.req_rdy !== 1'b1 || x_re !== 1'b0) begin n_err++; $display("FAIL reset_release got rdy=%b re=%b want 1/0", bus.req_rdy, x_re); end
  endtask

  task automatic test_basic;
    int a, r; bit ok, ok2; vec_t ex, ey;
    bus.rsp_rdy = 1'b1;
    do_req(3'd2, 3'd5, 1'b1, a, ok);
    n_cmp++; if (x_addr !== 6'd16 || y_addr !== 6'd5 || x_re !== 1'b1) begin n_err++; $display("FAIL basic_e0 got x=%0d y=%0d re=%b want 16/5/1", x_addr, y_addr, x_re); end
    @(negedge clk); bus.req_vld = 1'b0;
    wait_rsp(r, ok2);
    n_cmp++; if (!(ok && ok2) || (r - a) != N + 1) begin n_err++; $display("FAIL basic_latency got %0d want %0d", r - a, N + 1); end
    ex = exp_x_q.pop_front(); ey = exp_y_q.pop_front();
    n_cmp++; if (bus.x_r_row !== ex) begin n_err++; $display("FAIL basic_x got %h want %h", bus.x_r_row, ex); end
    n_cmp++; if (bus.y_r_col !== ey) begin n_err++; $display("FAIL basic_y got %h want %h", bus.y_r_col, ey); end
    @(negedge clk);
    n_cmp++; if (bus.rsp_vld !== 1'b0 || bus.req_rdy !== 1'b1) begin n_err++; $display("FAIL basic_one_cycle got vld=%b rdy=%b want 0/1", bus.rsp_vld, bus.req_rdy); end
    n_cmp++; if (bus.x_r_row !== ex) begin n_err++; $display("FAIL basic_keep got %h want %h", bus.x_r_row, ex); end
  endtask

  task automatic test_corner;
    int a, r; bit ok, ok2; vec_t ex, ey;
    logic [AW-1:0] lx, ly;
    lx = '0; ly = '0;
    bus.rsp_rdy = 1'b1;
    do_req(3'd7, 3'd7, 1'b0, a, ok);
    for (int t = 0; t < 20; t++) begin
      if (!x_re) break;
      lx = x_addr; ly = y_addr;
      @(negedge clk);
    end
    n_cmp++; if (lx !== 6'd63 || ly !== 6'd63) begin n_err++; $display("FAIL corner_addr got x=%0d y=%0d want 63/63", lx, ly); end
    wait_rsp(r, ok2);
    ex = exp_x_q.pop_front(); ey = exp_y_q.pop_front();
    n_cmp++; if (!(ok && ok2) || bus.x_r_row[7] !== 32'd63 || bus.x_r_row !== ex) begin n_err++; $display("FAIL corner_x got %0d want 63", bus.x_r_row[7]); end
    n_cmp++; if (bus.y_r_col[7] !== 32'd1063 || bus.y_r_col !== ey) begin n_err++; $display("FAIL corner_y got %0d want 1063", bus.y_r_col[7]); end
    @(negedge clk);
  endtask

  task automatic test_backpressure;
    int a, r; bit ok, ok2, stable, rdy_low, idle; vec_t ex, ey;
    stable = 1'b1; rdy_low = 1'b1; idle = 1'b1;
    bus.rsp_rdy = 1'b0;
    do_req(3'd3, 3'd6, 1'b0, a, ok);
    wait_rsp(r, ok2);
    ex = exp_x_q.pop_front(); ey = exp_y_q.pop_front();
    bus.req_vld = 1'b1; bus.i = 3'd1; bus.j = 3'd1;
    for (int t = 0; t < 5; t++) begin
      @(negedge clk);
      if (bus.x_r_row !== ex || bus.y_r_col !== ey || bus.rsp_vld !== 1'b1) stable = 1'b0;
      if (bus.req_rdy !== 1'b0) rdy_low = 1'b0;
      if (x_re !== 1'b0) idle = 1'b0;
    end
    n_cmp++; if (!(ok && ok2) || !stable) begin n_err++; $display("FAIL bp_stable got %b want 1", stable); end
    n_cmp++; if (!rdy_low) begin n_err++; $display("FAIL bp_req_rdy got high want 0"); end
    n_cmp++; if (!idle) begin n_err++; $display("FAIL bp_no_fetch got re=1 want 0"); end
    bus.req_vld = 1'b0;
    bus.rsp_rdy = 1'b1;
    @(negedge clk);
    n_cmp++; if (bus.rsp_vld !== 1'b0 || bus.req_rdy !== 1'b1) begin n_err++; $display("FAIL bp_release got vld=%b rdy=%b want 0/1", bus.rsp_vld, bus.req_rdy); end
  endtask

  task automatic test_back_to_back;
    int a1, a2, r; bit ok1, ok2, ok3; vec_t ex, ey;
    bus.rsp_rdy = 1'b1;
    do_req(3'd0, 3'd0, 1'b1, a1, ok1);
    bus.i = 3'd1; bus.j = 3'd3;
    wait_rsp(r, ok2);
    ex = exp_x_q.pop_front(); ey = exp_y_q.pop_front();
    n_cmp++; if (!(ok1 && ok2) || bus.x_r_row !== ex || bus.y_r_col !== ey) begin n_err++; $display("FAIL b2b_first got %h want %h", bus.x_r_row, ex); end
    do_req(3'd1, 3'd3, 1'b0, a2, ok1);
    n_cmp++; if (!ok1 || (a2 - a1) != N + 3) begin n_err++; $display("FAIL b2b_period got %0d want %0d", a2 - a1, N + 3); end
    wait_rsp(r, ok2);
    ex = exp_x_q.pop_front(); ey = exp_y_q.pop_front();
    ok3 = (bus.x_r_row === ex) && (bus.y_r_col === ey);
    n_cmp++; if (!ok2 || !ok3) begin n_err++; $display("FAIL b2b_second got x=%h y=%h want x=%h y=%h", bus.x_r_row, bus.y_r_col, ex, ey); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid;
    int a, r; bit ok, ok2, seen; vec_t ex, ey;
    seen = 1'b0;
    bus.rsp_rdy = 1'b1;
    do_req(3'd6, 3'd2, 1'b0, a, ok);
    for (int t = 0; t < 20; t++) begin
      if (x_addr == 6'd51) break;
      @(negedge clk);
    end
    rst = 1'b1;
    #1;
    n_cmp++; if (!ok || x_addr !== 6'd0 || y_addr !== 6'd0 || x_re !== 1'b0 || y_re !== 1'b0) begin n_err++; $display("FAIL rstmid_bram got x=%0d y=%0d re=%b want 0/0/0", x_addr, y_addr, x_re); end
    n_cmp++; if (bus.req_rdy !== 1'b1 || bus.rsp_vld !== 1'b0 || bus.x_r_row !== '0 || bus.y_r_col !== '0) begin n_err++; $display("FAIL rstmid_out got rdy=%b vld=%b want 1/0 and zero vectors", bus.req_rdy, bus.rsp_vld); end
    exp_x_q.delete(); exp_y_q.delete();
    @(negedge clk);
    rst = 1'b0;
    for (int t = 0; t < 15; t++) begin
      @(negedge clk);
      if (bus.rsp_vld !== 1'b0) seen = 1'b1;
    end
    n_cmp++; if (seen) begin n_err++; $display("FAIL rstmid_no_rsp got rsp_vld=1 want 0"); end
    do_req(3'd4, 3'd1, 1'b0, a, ok);
    wait_rsp(r, ok2);
    ex = exp_x_q.pop_front(); ey = exp_y_q.pop_front();
    n_cmp++; if (!(ok && ok2) || bus.x_r_row !== ex || bus.y_r_col !== ey) begin n_err++; $display("FAIL rstmid_next got x=%h y=%h want x=%h y=%h", bus.x_r_row, bus.y_r_col, ex, ey); end
    @(negedge clk);
  endtask

  task automatic test_ignore;
    int a, r; bit ok, ok2, idle; vec_t ex, ey;
    idle = 1'b1;
    bus.rsp_rdy = 1'b1;
    do_req(3'd5, 3'd0, 1'b0, a, ok);
    for (int t = 0; t < 4; t++) begin
      bus.req_vld = 1'b1; bus.i = 3'd2; bus.j = 3'd2;
      @(negedge clk);
    end
    bus.req_vld = 1'b0;
    wait_rsp(r, ok2);
    ex = exp_x_q.pop_front(); ey = exp_y_q.pop_front();
    n_cmp++; if (!(ok && ok2) || bus.x_r_row !== ex || bus.y_r_col !== ey) begin n_err++; $display("FAIL ignore_data got x=%h y=%h want x=%h y=%h", bus.x_r_row, bus.y_r_col, ex, ey); end
    repeat (3) begin
      @(negedge clk);
      if (x_re !== 1'b0 || bus.rsp_vld !== 1'b0) idle = 1'b0;
    end
    n_cmp++; if (!idle || exp_x_q.size() != 0) begin n_err++; $display("FAIL ignore_no_queue got activity=%b pending=%0d want 0/0", !idle, exp_x_q.size()); end
  endtask

  initial begin
    bus.req_vld = 1'b0;
    bus.i = '0;
    bus.j = '0;
    bus.rsp_rdy = 1'b0;
    test_reset;
    test_basic;
    test_corner;
    test_backpressure;
    test_back_to_back;
    test_reset_mid;
    test_ignore;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
